// File: rtl/qft_stream_engine_if.sv
// rtl/qft_stream_engine_if.sv - sample, twiddle and result signals of the QFT stream engine
interface qft_stream_engine_if #(
    parameter int LOG2N  = 2,
    parameter int DATA_W = 8,
    parameter int COEF_W = 12,
    parameter int OUT_W  = DATA_W + LOG2N / 2 + 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_r;
    logic signed [DATA_W-1:0] in_i;
    logic                     inv;
    logic [LOG2N-1:0]         tw_idx;
    logic signed [COEF_W-1:0] tw_cos;
    logic signed [COEF_W-1:0] tw_sin;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_r;
    logic signed [OUT_W-1:0]  out_i;
    logic [LOG2N-1:0]         out_idx;
    logic                     frame_done;

    modport slave (
        input  in_valid, in_r, in_i, inv, tw_cos, tw_sin, out_ready,
        output in_ready, tw_idx, out_valid, out_r, out_i, out_idx, frame_done
    );

    modport master (
        output in_valid, in_r, in_i, inv, tw_cos, tw_sin, out_ready,
        input  in_ready, tw_idx, out_valid, out_r, out_i, out_idx, frame_done
    );
endinterface

// File: rtl/qft_stream_engine.sv
// rtl/qft_stream_engine.sv - sequential N-point QFT with one shared complex MAC
module qft_stream_engine #(
    parameter int LOG2N  = 2,
    parameter int DATA_W = 8,
    parameter int COEF_W = 12,
    parameter int FRAC   = 10,
    parameter int OUT_W  = DATA_W + LOG2N / 2 + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    qft_stream_engine_if.slave   bus
);
    localparam int N     = 1 << LOG2N;
    localparam int P_W   = DATA_W + COEF_W + 1;
    localparam int ACC_W = P_W + LOG2N;
    localparam int SHIFT = FRAC + LOG2N / 2;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

    state_t                   state_q, state_d;
    logic [LOG2N-1:0]         j_q, j_d, k_q, k_d;
    logic                     inv_q, inv_d;
    logic signed [ACC_W-1:0]  acc_r_q, acc_r_d, acc_i_q, acc_i_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]  out_r_q, out_r_d, out_i_q, out_i_d;
    logic [LOG2N-1:0]         out_idx_q, out_idx_d;
    logic                     frame_done_q, frame_done_d;

    logic signed [DATA_W-1:0] buf_r [N];
    logic signed [DATA_W-1:0] buf_i [N];

    logic                     load_fire;
    logic signed [P_W-1:0]    a_x, b_x, c_x, s_x, prod_r, prod_i;
    logic signed [ACC_W-1:0]  sum_r, sum_i;

    assign bus.in_ready   = (state_q == S_LOAD) && !rst;
    assign load_fire      = bus.in_valid && bus.in_ready;
    assign bus.tw_idx     = (state_q == S_CALC) ? j_q * k_q : '0;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_r      = out_r_q;
    assign bus.out_i      = out_i_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.frame_done = frame_done_q;

    // Operands are widened before negation so that -(-full scale) of the sine stays exact.
    always_comb begin
        a_x    = P_W'(buf_r[j_q]);
        b_x    = P_W'(buf_i[j_q]);
        c_x    = P_W'(bus.tw_cos);
        s_x    = inv_q ? -P_W'(bus.tw_sin) : P_W'(bus.tw_sin);
        prod_r = a_x * c_x - b_x * s_x;
        prod_i = a_x * s_x + b_x * c_x;
        sum_r  = (j_q == '0) ? ACC_W'(prod_r) : acc_r_q + ACC_W'(prod_r);
        sum_i  = (j_q == '0) ? ACC_W'(prod_i) : acc_i_q + ACC_W'(prod_i);
    end

    always_comb begin
        state_d      = state_q;
        j_d          = j_q;
        k_d          = k_q;
        inv_d        = inv_q;
        acc_r_d      = acc_r_q;
        acc_i_d      = acc_i_q;
        out_valid_d  = out_valid_q;
        out_r_d      = out_r_q;
        out_i_d      = out_i_q;
        out_idx_d    = out_idx_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (load_fire) begin
                    if (j_q == '0) inv_d = bus.inv;
                    if (j_q == LAST) begin
                        state_d = S_CALC;
                        j_d     = '0;
                        k_d     = '0;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            S_CALC: begin
                acc_r_d = sum_r;
                acc_i_d = sum_i;
                if (j_q == LAST) begin
                    state_d     = S_OUT;
                    j_d         = '0;
                    out_valid_d = 1'b1;
                    out_r_d     = OUT_W'(sum_r >>> SHIFT);
                    out_i_d     = OUT_W'(sum_i >>> SHIFT);
                    out_idx_d   = k_q;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    j_d         = '0;
                    if (k_q == LAST) begin
                        frame_done_d = 1'b1;
                        k_d          = '0;
                        state_d      = S_LOAD;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_CALC;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_LOAD;
            j_q          <= '0;
            k_q          <= '0;
            inv_q        <= 1'b0;
            acc_r_q      <= '0;
            acc_i_q      <= '0;
            out_valid_q  <= 1'b0;
            out_r_q      <= '0;
            out_i_q      <= '0;
            out_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            j_q          <= j_d;
            k_q          <= k_d;
            inv_q        <= inv_d;
            acc_r_q      <= acc_r_d;
            acc_i_q      <= acc_i_d;
            out_valid_q  <= out_valid_d;
            out_r_q      <= out_r_d;
            out_i_q      <= out_i_d;
            out_idx_q    <= out_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Sample buffer is plain storage; a partial frame after reset is simply overwritten.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            buf_r[j_q] <= bus.in_r;
            buf_i[j_q] <= bus.in_i;
        end
    end
endmodule

// File: tb/tb_qft_stream_engine.sv
// tb/tb_qft_stream_engine.sv - self-checking bench for qft_stream_engine
module tb_qft_stream_engine;
    localparam int LOG2N  = 2;
    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int COEF_W = 12;
    localparam int FRAC   = 10;
    localparam int OUT_W  = DATA_W + LOG2N / 2 + 2;
    localparam int SHIFT  = FRAC + LOG2N / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   frame_r [N];
    int   frame_i [N];
    int   exp_r   [N];
    int   exp_i   [N];

    qft_stream_engine_if #(.LOG2N(LOG2N), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) bus ();

    qft_stream_engine #(
        .LOG2N(LOG2N), .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC(FRAC), .OUT_W(OUT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int cos_q(input int idx);
        case (idx % N)
            0:       return 1024;
            2:       return -1024;
            default: return 0;
        endcase
    endfunction

    function automatic int sin_q(input int idx);
        case (idx % N)
            1:       return 1024;
            3:       return -1024;
            default: return 0;
        endcase
    endfunction

    always_comb begin
        bus.tw_cos = COEF_W'(cos_q(int'(bus.tw_idx)));
        bus.tw_sin = COEF_W'(sin_q(int'(bus.tw_idx)));
    end

    task automatic check(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Direct DFT sum with exact quarter-turn twiddles, scaled by 1/sqrt(N) with floor.
    task automatic model(input bit inv_b);
        for (int k = 0; k < N; k++) begin
            longint sr = 0;
            longint si = 0;
            for (int j = 0; j < N; j++) begin
                longint c = cos_q(j * k);
                longint s = inv_b ? -sin_q(j * k) : sin_q(j * k);
                sr += frame_r[j] * c - frame_i[j] * s;
                si += frame_r[j] * s + frame_i[j] * c;
            end
            exp_r[k] = int'(sr >>> SHIFT);
            exp_i[k] = int'(si >>> SHIFT);
        end
    endtask

    task automatic set_frame(input int r0, r1, r2, r3, i0, i1, i2, i3);
        frame_r[0] = r0; frame_r[1] = r1; frame_r[2] = r2; frame_r[3] = r3;
        frame_i[0] = i0; frame_i[1] = i1; frame_i[2] = i2; frame_i[3] = i3;
    endtask

    task automatic set_exp(input int r0, r1, r2, r3, i0, i1, i2, i3);
        exp_r[0] = r0; exp_r[1] = r1; exp_r[2] = r2; exp_r[3] = r3;
        exp_i[0] = i0; exp_i[1] = i1; exp_i[2] = i2; exp_i[3] = i3;
    endtask

    task automatic send_frame(input bit inv_b, input bit gaps);
        for (int j = 0; j < N; j++) begin
            if (gaps) begin
                int idle = $urandom_range(0, 2);
                for (int g = 0; g < idle; g++) begin
                    bus.in_valid = 1'b0;
                    bus.in_r     = DATA_W'($urandom);
                    bus.in_i     = DATA_W'($urandom);
                    bus.inv      = ~inv_b;
                    step();
                end
            end
            bus.in_valid = 1'b1;
            bus.in_r     = DATA_W'(frame_r[j]);
            bus.in_i     = DATA_W'(frame_i[j]);
            bus.inv      = (j == 0) ? inv_b : ~inv_b;
            check("in_ready_load", bus.in_ready, 1);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(input int n_res, input int stall_k, input int stall_n);
        for (int k = 0; k < n_res; k++) begin
            int wait_n = 0;
            while (!bus.out_valid && wait_n < 50) begin
                step();
                wait_n++;
            end
            check("result_latency", wait_n, N);
            if (!bus.out_valid) return;
            check("out_idx", bus.out_idx, k);
            check("out_r", $signed(bus.out_r), exp_r[k]);
            check("out_i", $signed(bus.out_i), exp_i[k]);
            if (k == stall_k) begin
                for (int s = 0; s < stall_n; s++) begin
                    step();
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_idx", bus.out_idx, k);
                    check("stall_r", $signed(bus.out_r), exp_r[k]);
                    check("stall_i", $signed(bus.out_i), exp_i[k]);
                    check("stall_in_ready", bus.in_ready, 0);
                end
            end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            check("frame_done", bus.frame_done, (k == N - 1) ? 1 : 0);
            check("out_valid_drop", bus.out_valid, 0);
            if (k == N - 1) check("in_ready_after_done", bus.in_ready, 1);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_r      = '0;
        bus.in_i      = '0;
        bus.inv       = 1'b0;
        bus.out_ready = 1'b0;

        step();
        step();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_r", bus.out_r, 0);
        check("rst_out_i", bus.out_i, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_tw_idx", bus.tw_idx, 0);
        check("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        check("in_ready_release", bus.in_ready, 1);

        set_frame(64, 0, 0, 0, 0, 0, 0, 0);
        set_exp(32, 32, 32, 32, 0, 0, 0, 0);
        send_frame(1'b0, 1'b0);
        recv(N, -1, 0);

        set_frame(64, 64, 64, 64, 0, 0, 0, 0);
        set_exp(128, 0, 0, 0, 0, 0, 0, 0);
        send_frame(1'b0, 1'b0);
        recv(N, -1, 0);

        set_frame(0, 64, 0, 0, 0, 0, 0, 0);
        set_exp(32, 0, -32, 0, 0, 32, 0, -32);
        send_frame(1'b0, 1'b0);
        recv(N, -1, 0);
        set_exp(32, 0, -32, 0, 0, -32, 0, 32);
        send_frame(1'b1, 1'b0);
        recv(N, -1, 0);

        set_frame(1, 0, 0, 0, 0, 0, 0, 0);
        set_exp(0, 0, 0, 0, 0, 0, 0, 0);
        send_frame(1'b0, 1'b0);
        recv(N, -1, 0);
        set_frame(-1, 0, 0, 0, 0, 0, 0, 0);
        set_exp(-1, -1, -1, -1, 0, 0, 0, 0);
        send_frame(1'b0, 1'b0);
        recv(N, -1, 0);
        set_frame(-128, -128, -128, -128, -128, -128, -128, -128);
        set_exp(-256, 0, 0, 0, -256, 0, 0, 0);
        send_frame(1'b0, 1'b0);
        recv(N, -1, 0);

        for (int j = 0; j < N; j++) begin
            frame_r[j] = int'($urandom_range(0, 255)) - 128;
            frame_i[j] = int'($urandom_range(0, 255)) - 128;
        end
        model(1'b0);
        send_frame(1'b0, 1'b1);
        recv(N, 1, 5);

        set_frame(64, 0, 0, 0, 0, 0, 0, 0);
        set_exp(32, 32, 32, 32, 0, 0, 0, 0);
        send_frame(1'b0, 1'b0);
        recv(2, -1, 0);
        step();
        check("tw_idx_k2_j1", bus.tw_idx, 2);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_tw_idx", bus.tw_idx, 0);
        check("async_rst_in_ready", bus.in_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_out_valid", bus.out_valid, 0);
        send_frame(1'b0, 1'b0);
        recv(N, -1, 0);

        for (int f = 0; f < 6; f++) begin
            bit inv_b = 1'($urandom);
            for (int j = 0; j < N; j++) begin
                frame_r[j] = int'($urandom_range(0, 255)) - 128;
                frame_i[j] = int'($urandom_range(0, 255)) - 128;
            end
            model(inv_b);
            send_frame(inv_b, 1'($urandom));
            recv(N, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/qft_stream_engine.md
# qft_stream_engine

Sequential, parametrised N-point quantum Fourier transform engine for the QFT mathematical model. It accepts one frame of N complex state-vector amplitudes over a valid/ready stream and buffers it. It then computes every output amplitude out[k] = (1/√N)·Σj in[j]·e^(±i2πjk/N) with a single shared complex MAC, reading twiddles from an external cos/sin lookup table. Results stream out one per k with backpressure. This replaces the fixed 4-point, fully combinational row calculator.

## Interface
- LOG2N, 2, log2 of the point count N; must be even (2, 4, 6) so that 1/√N is an exact shift.
- DATA_W, 8, signed input amplitude width (integer samples).
- COEF_W, 12, signed twiddle width, Q1.10 format (sign, 1 integer bit, 10 fractional bits).
- FRAC, 10, fractional bits of the twiddle.
- OUT_W, DATA_W+LOG2N/2+2, signed output width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine accepts a sample (high only in LOAD, forced 0 while rst high).
- in_r, in_i  in  DATA_W each  real/imag of sample j, in order j=0..N-1.
- inv  in  1  inverse transform select; sampled with sample j=0.
- tw_idx  out  LOG2N  twiddle table address (j·k) mod N.
- tw_cos, tw_sin  in  COEF_W each  cos/sin(2π·tw_idx/N), returned combinationally in the same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_r, out_i  out  OUT_W each  real/imag of out[k].
- out_idx  out  LOG2N  k of the presented result.
- frame_done  out  1  one-cycle pulse on acceptance of k=N-1.

## Operation
- The state machine has three states: LOAD, CALC and OUT. Reset enters LOAD with j=0, k=0 and the accumulators cleared. On reset, out_valid, out_r, out_i, out_idx, frame_done and tw_idx are all 0.
- LOAD
  - Each in_valid&in_ready cycle writes (in_r, in_i) to buffer[j] and increments j.
  - inv is latched when j=0.
  - Accepting j=N-1 moves to CALC with j=0 and k=0.
- CALC
  - Each cycle reads buffer[j] and drives tw_idx=(j·k)&(N-1).
  - The effective sine s is tw_sin, or -tw_sin when inv is latched. The cosine is c=tw_cos.
  - Complex product, full precision (DATA_W+COEF_W+1 bits): pr=a·c-b·s, pi=a·s+b·c.
  - At j=0 the accumulators load the product; otherwise they add it. Accumulators are DATA_W+COEF_W+1+LOG2N bits wide, so no overflow is possible.
  - After the j=N-1 term the state moves to OUT.
  - out_r/out_i = accumulator >>> (FRAC+LOG2N/2): arithmetic shift, floor rounding, truncated to OUT_W.
  - out_idx=k.
- OUT
  - out_valid=1. out_r, out_i and out_idx are held stable until out_ready.
  - On handshake with k<N-1: k increments, j=0, and the state returns to CALC.
  - On handshake with k=N-1: frame_done pulses, k=0, j=0, and the state returns to LOAD.
- The twiddle table must hold exact values at multiples of π/2 (±1024, 0); other entries are rounded by the table, not by this block.
- Asynchronous reset in any state returns to LOAD, discards any partial frame or result, and drops out_valid immediately.
- in_valid outside LOAD is ignored (in_ready=0), so there is no overlap between frames.

## Timing
- in_ready is combinational from the state.
- out_valid, out_r, out_i, out_idx and frame_done are registered.
- Minimum frame load is N cycles.
- out_valid rises N cycles after entering CALC. The first result appears N cycles after the cycle in which sample N-1 is accepted.
- With out_ready held high, each result takes N+1 cycles, and the full frame takes N+N·(N+1) cycles. For N=4 that is 24 cycles.
- After frame_done, in_ready is high on the next cycle.
- Twiddle lookup is zero-latency. tw_idx is valid only in CALC and is 0 elsewhere.

## Test plan
All cases use N=4 unless noted.
1. Delta input: in=[64,0,0,0], inv=0. Required: all four outputs are (32,0), out_idx runs 0..3, and frame_done pulses with k=3.
2. Uniform input: in=[64,64,64,64]. Required: k=0 gives (128,0); k=1..3 give (0,0).
3. Shifted delta: in=[0,64,0,0]. Required with inv=0: k0..k3 are (32,0), (0,32), (-32,0), (0,-32). Required with inv=1: k1=(0,-32) and k3=(0,32).
4. Rounding: in=[1,0,...] gives out 0 for every k. in=[-1,0,...] gives -1 for every k (floor). Also check that in=[-128-128i,...] all-equal at k=0 gives (-256,-256) without overflow.
5. Backpressure:
   - Hold out_ready low 5 cycles on k=1. Required: out_r, out_i and out_idx stay stable, k does not advance, and in_ready=0 throughout.
   - Toggle in_valid during LOAD. Required: only handshaked samples are stored.
6. Reset mid-CALC (k=2, j=1). Required: out_valid=0 at once and in_ready=1 after release. A new frame with in=[64,0,0,0] then produces all outputs (32,0).
